// File: rtl/node_invoker_if.sv
// Host request bus and node ST/RD bus seen by the node invoker.
interface node_invoker_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNTW  = 8
);
  logic             req;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dout;
  logic             to;
  logic [CNTW-1:0]  ops;
  logic             n_st;
  logic [WIDTH-1:0] n_in0;
  logic [WIDTH-1:0] n_in1;
  logic             n_rd;
  logic [WIDTH-1:0] n_res;

  // Invoker side: accepts host requests, initiates node operations.
  modport master (
    input  req, a, b, n_rd, n_res,
    output busy, done, dout, to, ops, n_st, n_in0, n_in1
  );

  // Environment side: host plus node.
  modport slave (
    output req, a, b, n_rd, n_res,
    input  busy, done, dout, to, ops, n_st, n_in0, n_in1
  );
endinterface

// File: rtl/node_invoker.sv
// Initiator of the node start/ready protocol: issues one operand pair,
// waits for a ready edge (or the watchdog), returns the result with DONE.
module node_invoker #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNTW    = 8
) (
  input  logic           clk,
  input  logic           rst,
  node_invoker_if.master bus
);

  localparam int unsigned WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    FIN   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             rd_q, rd_d;
  logic [WDW-1:0]   wd_q, wd_d;
  logic             n_st_q, n_st_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             to_q, to_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] n_in0_q, n_in0_d;
  logic [WIDTH-1:0] n_in1_q, n_in1_d;
  logic [CNTW-1:0]  ops_q, ops_d;
  logic             ready_edge_c;

  // Only a rising ready counts; a level left high by a previous op does not.
  assign ready_edge_c = bus.n_rd & ~rd_q;

  // Next-state and next-output logic for the invoke sequence.
  always_comb begin
    state_d = state_q;
    rd_d    = bus.n_rd;
    wd_d    = wd_q;
    n_st_d  = n_st_q;
    busy_d  = busy_q;
    done_d  = done_q;
    to_d    = to_q;
    dout_d  = dout_q;
    n_in0_d = n_in0_q;
    n_in1_d = n_in1_q;
    ops_d   = ops_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          n_in0_d = bus.a;
          n_in1_d = bus.b;
          n_st_d  = 1'b1;
          busy_d  = 1'b1;
          wd_d    = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // Node cannot be ready yet, so a ready edge here is ignored.
        n_st_d  = 1'b0;
        state_d = WAIT;
      end
      WAIT: begin
        if (ready_edge_c) begin
          dout_d  = bus.n_res;
          to_d    = 1'b0;
          done_d  = 1'b1;
          ops_d   = ops_q + CNTW'(1);
          state_d = FIN;
        end else if (wd_q == WD_LAST) begin
          dout_d  = '0;
          to_d    = 1'b1;
          done_d  = 1'b1;
          state_d = FIN;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      FIN: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      wd_q    <= '0;
      n_st_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      dout_q  <= '0;
      n_in0_q <= '0;
      n_in1_q <= '0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wd_q    <= wd_d;
      n_st_q  <= n_st_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      to_q    <= to_d;
      dout_q  <= dout_d;
      n_in0_q <= n_in0_d;
      n_in1_q <= n_in1_d;
      ops_q   <= ops_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.dout  = dout_q;
  assign bus.to    = to_q;
  assign bus.ops   = ops_q;
  assign bus.n_st  = n_st_q;
  assign bus.n_in0 = n_in0_q;
  assign bus.n_in1 = n_in1_q;

endmodule

// File: tb/tb_node_invoker.sv
// Directed bench for node_invoker: host and node driven from one sequence,
// expected completions queued at request time and checked at DONE.
module tb_node_invoker;

  localparam int unsigned WIDTH   = 16;
  localparam int unsigned TIMEOUT = 10;
  localparam int unsigned CNTW    = 2;

  typedef struct {
    logic [WIDTH-1:0] dout;
    logic             to;
    logic [CNTW-1:0]  ops;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];
  logic [CNTW-1:0] ops_exp = '0;

  node_invoker_if #(.WIDTH(WIDTH), .CNTW(CNTW)) bus ();

  node_invoker #(
    .WIDTH  (WIDTH),
    .TIMEOUT(TIMEOUT),
    .CNTW   (CNTW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Queue an expected completion; OPS model advances only on success.
  task automatic push_exp(input logic [WIDTH-1:0] dout, input logic to);
    exp_t e;
    if (!to) ops_exp = ops_exp + CNTW'(1);
    e.dout = dout;
    e.to   = to;
    e.ops  = ops_exp;
    sb.push_back(e);
  endtask

  // Advance until DONE (bounded), compare against scoreboard, check strobe width.
  task automatic wait_done(input int bound, output int cyc);
    exp_t e;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < bound) begin
      tick();
      cyc++;
    end
    chk("done_seen", 32'(bus.done), 32'd1);
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("dout", 32'(bus.dout), 32'(e.dout));
        chk("to", 32'(bus.to), 32'(e.to));
        chk("ops", 32'(bus.ops), 32'(e.ops));
        chk("busy_at_done", 32'(bus.busy), 32'd1);
      end
      tick();
      chk("done_one_cycle", 32'(bus.done), 32'd0);
      chk("busy_after_done", 32'(bus.busy), 32'd0);
    end
  endtask

  // Start a request and step into the ISSUE cycle.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.req = 1'b1;
    bus.a   = a;
    bus.b   = b;
    tick();
    chk("n_st_issue", 32'(bus.n_st), 32'd1);
    chk("busy_issue", 32'(bus.busy), 32'd1);
    chk("n_in0", 32'(bus.n_in0), 32'(a));
    chk("n_in1", 32'(bus.n_in1), 32'(b));
  endtask

  initial begin
    int cyc;
    bit seen;
    bus.req = 1'b0; bus.a = '0; bus.b = '0; bus.n_rd = 1'b0; bus.n_res = '0;

    // Reset state
    tick(); tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_dout", 32'(bus.dout), 32'd0);
    chk("rst_to", 32'(bus.to), 32'd0);
    chk("rst_ops", 32'(bus.ops), 32'd0);
    chk("rst_n_st", 32'(bus.n_st), 32'd0);
    chk("rst_n_in0", 32'(bus.n_in0), 32'd0);
    chk("rst_n_in1", 32'(bus.n_in1), 32'd0);
    rst = 1'b1;
    tick();

    // 3-cycle node, result A+B
    push_exp(16'h0046, 1'b0);
    issue(16'h0012, 16'h0034);
    bus.req = 1'b0; bus.a = 16'hFFFF; bus.b = 16'hFFFF;
    tick();
    chk("n_st_single", 32'(bus.n_st), 32'd0);
    chk("n_in0_hold", 32'(bus.n_in0), 32'h0012);
    tick(); tick();
    bus.n_rd = 1'b1; bus.n_res = 16'h0046;
    wait_done(20, cyc);
    chk("lat3_cycles", 32'(cyc), 32'd1);

    // Stale ready held from previous op
    push_exp(16'hBEEF, 1'b0);
    issue(16'h0001, 16'h0002);
    bus.req = 1'b0;
    tick();
    tick();
    chk("stale_no_capture", 32'(bus.done), 32'd0);
    bus.n_rd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stale_wait", 32'(bus.done), 32'd0);
    end
    bus.n_rd = 1'b1; bus.n_res = 16'hBEEF;
    wait_done(20, cyc);
    bus.n_rd = 1'b0;

    // Watchdog timeout with node never ready
    push_exp(16'h0000, 1'b1);
    issue(16'h0005, 16'h0006);
    bus.req = 1'b0;
    wait_done(30, cyc);
    chk("timeout_cycles", 32'(cyc), 32'd11);

    // Normal op after timeout clears TO, minimum latency node
    push_exp(16'h0101, 1'b0);
    issue(16'h0100, 16'h0001);
    bus.req = 1'b0;
    tick();
    bus.n_rd = 1'b1; bus.n_res = 16'h0101;
    wait_done(20, cyc);
    chk("min_latency", 32'(cyc), 32'd1);
    bus.n_rd = 1'b0;

    // REQ held high across three back-to-back ops (OPS wraps at 2 bits)
    for (int i = 0; i < 3; i++) begin
      logic [WIDTH-1:0] av, bv;
      av = WIDTH'(i * 16 + 1);
      bv = WIDTH'(i + 2);
      push_exp(av + bv, 1'b0);
      issue(av, bv);
      tick();
      bus.n_rd = 1'b1; bus.n_res = av + bv;
      wait_done(20, cyc);
      chk("no_accept_in_fin", 32'(bus.n_st), 32'd0);
      bus.n_rd = 1'b0;
    end
    bus.req = 1'b0;
    tick();

    // Ready edge on the final watchdog cycle beats the timeout
    push_exp(16'h5A5A, 1'b0);
    issue(16'h0A0A, 16'h5050);
    bus.req = 1'b0;
    for (int i = 0; i < int'(TIMEOUT); i++) tick();
    chk("edge_wait_busy", 32'(bus.busy), 32'd1);
    bus.n_rd = 1'b1; bus.n_res = 16'h5A5A;
    wait_done(5, cyc);
    chk("edge_vs_timeout", 32'(cyc), 32'd1);
    bus.n_rd = 1'b0;

    // Asynchronous reset during WAIT abandons the op
    issue(16'h1111, 16'h2222);
    bus.req = 1'b0;
    tick(); tick();
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_n_in0", 32'(bus.n_in0), 32'd0);
    chk("arst_ops", 32'(bus.ops), 32'd0);
    chk("arst_dout", 32'(bus.dout), 32'd0);
    ops_exp = '0;
    tick(); tick();
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.done === 1'b1) seen = 1'b1;
    end
    chk("no_done_after_rst", 32'(seen), 32'd0);
    push_exp(16'h000F, 1'b0);
    issue(16'h0007, 16'h0008);
    bus.req = 1'b0;
    tick();
    bus.n_rd = 1'b1; bus.n_res = 16'h000F;
    wait_done(20, cyc);
    bus.n_rd = 1'b0;

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
